// File: rtl/hls_stream_pkg.sv
// Shared constants for the frame-streaming pixel blocks: operation codes and FSM states.
package hls_stream_pkg;

  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_INV  = 2'd1;
  localparam logic [1:0] MODE_THR  = 2'd2;
  localparam logic [1:0] MODE_SADD = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/hls_pixel_op.sv
// Combinational per-pixel operation: pass, invert, threshold or saturating add.
module hls_pixel_op
  import hls_stream_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] param,
  input  logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] y
);

  logic [DATA_W:0] sum;

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    y   = x;
    sum = {1'b0, x} + {1'b0, param};
    case (mode)
      MODE_PASS: y = x;
      MODE_INV:  y = ~x;
      MODE_THR:  y = (x >= param) ? '1 : '0;
      MODE_SADD: y = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
      default:   y = x;
    endcase
  end

endmodule

// File: rtl/hls_frame_stream.sv
// Frame-level ap_ctrl_hs wrapper: streams FRAME_LEN pixels per ap_start through hls_pixel_op
// with a one-deep registered output stage and valid/ready on both sides.
module hls_frame_stream
  import hls_stream_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 10,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] param,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic [CNT_W-1:0] LEN  = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  state_t            state;
  logic [CNT_W-1:0]  in_cnt;
  logic [CNT_W-1:0]  out_cnt;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] param_q;
  logic [DATA_W-1:0] op_y;
  logic              in_hs;
  logic              out_hs;

  // Operation runs on the configuration captured at ap_start, not the live inputs.
  hls_pixel_op #(.DATA_W(DATA_W)) u_pixel_op (
    .mode  (mode_q),
    .param (param_q),
    .x     (in_data),
    .y     (op_y)
  );

  // Accept a new pixel only if the output register is empty or draining this cycle.
  assign in_ready = (state == RUN) && (in_cnt < LEN) && (!out_valid || out_ready);
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= IDLE;
      ap_done   <= 1'b0;
      ap_idle   <= 1'b1;
      ap_ready  <= 1'b0;
      in_cnt    <= '0;
      out_cnt   <= '0;
      mode_q    <= MODE_PASS;
      param_q   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update based on pre-edge values.
      ap_done  <= 1'b0;
      ap_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (ap_start) begin
            mode_q  <= mode;
            param_q <= param;
            in_cnt  <= '0;
            out_cnt <= '0;
            ap_idle <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          if (in_hs) begin
            out_data  <= op_y;
            out_valid <= 1'b1;
            in_cnt    <= in_cnt + CNT_W'(1);
          end else if (out_hs) begin
            out_valid <= 1'b0;
          end
          if (out_hs) begin
            out_cnt <= out_cnt + CNT_W'(1);
            if (out_cnt == LAST) begin
              ap_done  <= 1'b1;
              ap_ready <= 1'b1;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          ap_idle <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          ap_idle   <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
